// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared state encodings and nibble width for the serial adder
package adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - start/done request bus between requester and serial adder
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             i_start;
  logic             i_sub;
  logic             i_c_in;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_ready;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_sub, i_c_in, i_a, i_b,
    input  o_ready, o_busy, o_done, o_sum, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_sub, i_c_in, i_a, i_b,
    output o_ready, o_busy, o_done, o_sum, o_cout, o_ovf
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_full_adder_4bit.sv
// rtl/nibble_serial_adder_ctrl_full_adder_4bit.sv - 4-bit ripple-carry adder shared across nibbles
module full_adder_4bit
  import adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             c_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = c_i;
    for (int i = 0; i < NIB_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced LS nibble first through one 4-bit adder
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  nibble_serial_adder_ctrl_if.slave      bus
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] a_nib, b_nib, nib_sum;
  logic             nib_cout;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  full_adder_4bit u_adder (
    .a_i   (a_nib),
    .b_i   (b_nib),
    .c_i   (carry_q),
    .sum_o (nib_sum),
    .c_o   (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_RUN;
          a_d     = bus.i_a;
          // subtract as A + ~B + 1; carry-in is forced so i_c_in has no effect
          b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
          carry_d = bus.i_sub | bus.i_c_in;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[i*NIB_W +: NIB_W] = nib_sum;
          end
        end
        carry_d = nib_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cout_d  = nib_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_busy  = (state_q == ST_RUN);
  assign bus.o_done  = (state_q == ST_DONE);
  assign bus.o_sum   = sum_q;
  assign bus.o_cout  = cout_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for the nibble-serial adder (WIDTH 16 and 4)
module tb_nibble_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp16_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp4_t;

  logic clk;
  logic rst;

  int n_pass;
  int n_total;

  exp16_t q16[$];
  exp4_t  q4[$];

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) b16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  b4 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp16_t e;
    if (!rst && b16.o_done) begin
      check("done16_has_expectation", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("sum16", 32'(b16.o_sum), 32'(e.sum));
        check("cout16", 32'(b16.o_cout), 32'(e.cout));
        check("ovf16", 32'(b16.o_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp4_t e;
    if (!rst && b4.o_done) begin
      check("done4_has_expectation", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("sum4", 32'(b4.o_sum), 32'(e.sum));
        check("cout4", 32'(b4.o_cout), 32'(e.cout));
        check("ovf4", 32'(b4.o_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic wait_ready16();
    int tmo;
    @(negedge clk);
    tmo = 0;
    while (!b16.o_ready && tmo < 30) begin
      @(negedge clk);
      tmo++;
    end
    check("ready16_within_budget", 32'(b16.o_ready), 32'd1);
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    b16.i_a     = a;
    b16.i_b     = b;
    b16.i_sub   = sub;
    b16.i_c_in  = cin;
    b16.i_start = 1'b1;
  endtask

  task automatic push16(input logic [15:0] s, input logic c, input logic o);
    exp16_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    q16.push_back(e);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    wait_ready16();
    drive16(a, b, sub, cin);
    push16(es, ec, eo);
    @(posedge clk);
    @(negedge clk);
    b16.i_start = 1'b0;
    lat = 1;
    while (!b16.o_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency16", 32'(lat), 32'd5);
  endtask

  initial begin
    int t1, t2, cyc, lat;
    exp4_t e4;
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    b16.i_start = 1'b0; b16.i_sub = 1'b0; b16.i_c_in = 1'b0; b16.i_a = '0; b16.i_b = '0;
    b4.i_start  = 1'b0; b4.i_sub  = 1'b0; b4.i_c_in  = 1'b0; b4.i_a  = '0; b4.i_b  = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(b16.o_ready), 32'd1);
    check("rst_busy", 32'(b16.o_busy), 32'd0);
    check("rst_done", 32'(b16.o_done), 32'd0);
    check("rst_sum", 32'(b16.o_sum), 32'd0);
    check("rst_cout_ovf", 32'({b16.o_cout, b16.o_ovf}), 32'd0);
    rst = 1'b0;

    run16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run16(16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run16(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);

    // starts pulsed during RUN and during DONE must be dropped
    wait_ready16();
    drive16(16'h1234, 16'h4321, 1'b0, 1'b0);
    push16(16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    b16.i_start = 1'b0;
    cyc = 0;
    while (!b16.o_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_done_seen", 32'(b16.o_done), 32'd1);
    drive16(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    @(negedge clk);
    b16.i_start = 1'b0;
    check("busy_sum_held", 32'(b16.o_sum), 32'h5555);
    check("busy_ready_after_done", 32'(b16.o_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("busy_not_restarted", 32'(b16.o_busy), 32'd0);
    check("busy_sum_still_held", 32'(b16.o_sum), 32'h5555);

    // held start: back-to-back operations one per NIB+2 cycles
    wait_ready16();
    drive16(16'h0003, 16'h0004, 1'b0, 1'b0);
    push16(16'h0007, 1'b0, 1'b0);
    push16(16'h0007, 1'b0, 1'b0);
    cyc = 0;
    while (!b16.o_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    t1 = cyc;
    @(negedge clk);
    cyc++;
    while (!b16.o_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    t2 = cyc;
    b16.i_start = 1'b0;
    check("held_start_period", 32'(t2 - t1), 32'd6);

    // async reset mid-RUN after two nibbles, asserted between edges
    wait_ready16();
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    b16.i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 32'(b16.o_ready), 32'd1);
    check("arst_busy", 32'(b16.o_busy), 32'd0);
    check("arst_done", 32'(b16.o_done), 32'd0);
    check("arst_sum", 32'(b16.o_sum), 32'd0);
    check("arst_cout", 32'(b16.o_cout), 32'd0);
    check("arst_ovf", 32'(b16.o_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // WIDTH=4 instance
    @(negedge clk);
    check("w4_ready", 32'(b4.o_ready), 32'd1);
    b4.i_a = 4'h9; b4.i_b = 4'h8; b4.i_sub = 1'b0; b4.i_c_in = 1'b0; b4.i_start = 1'b1;
    e4.sum = 4'h1; e4.cout = 1'b1; e4.ovf = 1'b1;
    q4.push_back(e4);
    @(posedge clk);
    @(negedge clk);
    b4.i_start = 1'b0;
    lat = 1;
    while (!b4.o_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency4", 32'(lat), 32'd2);

    repeat (4) @(negedge clk);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
